prog_boot_ctrl: RTL and testbench

Boot and program-load controller that sits between the programming UART receiver, the instruction memory port and the core reset inside the SoC top. When programming mode is requested it holds the core in reset. It assembles received bytes into 32-bit little-endian words and writes them sequentially into instruction memory until the end-of-program word arrives. It then releases the core and hands the memory port to the core's instruction fetch.

---
 rtl/prog_boot_ctrl.sv | 177 +++++++++++++++++
 tb/tb_prog_boot_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_boot_ctrl.sv
// Boot/program loader: packs UART bytes into LE words, writes them to imem, then releases the core.
// Registered outputs except RUN-state fetch passthrough (0 cycles); WRITE holds until mem_gnt_i, bytes arriving in WRITE are dropped.
module prog_boot_ctrl #(
   parameter int          ADDR_W   = 13,
   parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              prog_i,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   input  logic              core_req_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   output logic              core_gnt_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i,
   output logic              core_reset_o,
   output logic              boot_o,
   output logic              err_o
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_RUN} state_t;

   state_t            r_state, w_state;
   logic [1:0]        r_sync;
   logic              r_prog_d;
   logic [1:0]        r_settle, w_settle;
   logic [31:0]       r_word, w_word;
   logic [1:0]        r_byte_idx, w_byte_idx;
   logic [ADDR_W-1:0] r_word_cnt, w_word_cnt;
   logic              r_err, w_err;
   logic              r_core_reset, w_core_reset;
   logic              r_boot, w_boot;
   logic              r_mem_req, w_mem_req;
   logic              r_mem_we, w_mem_we;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
   logic [31:0]       r_mem_wdata, w_mem_wdata;
   logic [31:0]       w_asm;
   logic              w_prog_rise;
   logic              w_run;

   assign w_prog_rise = r_sync[1] & ~r_prog_d;
   assign w_run       = (r_state == S_RUN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_sync       <= 2'b00;
         r_prog_d     <= 1'b0;
         r_settle     <= 2'd0;
         r_word       <= 32'd0;
         r_byte_idx   <= 2'd0;
         r_word_cnt   <= '0;
         r_err        <= 1'b0;
         r_core_reset <= 1'b1;
         r_boot       <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= 32'd0;
      end else begin
         r_state      <= w_state;
         r_sync       <= {r_sync[0], prog_i};
         r_prog_d     <= r_sync[1];
         r_settle     <= w_settle;
         r_word       <= w_word;
         r_byte_idx   <= w_byte_idx;
         r_word_cnt   <= w_word_cnt;
         r_err        <= w_err;
         r_core_reset <= w_core_reset;
         r_boot       <= w_boot;
         r_mem_req    <= w_mem_req;
         r_mem_we     <= w_mem_we;
         r_mem_addr   <= w_mem_addr;
         r_mem_wdata  <= w_mem_wdata;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_settle     = r_settle;
      w_word       = r_word;
      w_byte_idx   = r_byte_idx;
      w_word_cnt   = r_word_cnt;
      w_err        = r_err;
      w_core_reset = r_core_reset;
      w_boot       = r_boot;
      w_mem_req    = r_mem_req;
      w_mem_we     = r_mem_we;
      w_mem_addr   = r_mem_addr;
      w_mem_wdata  = r_mem_wdata;
      // Word as it will look once the incoming byte lands; the 4th byte is judged on this, not on r_word.
      w_asm = r_word;
      w_asm[{r_byte_idx, 3'b000} +: 8] = rx_data_i;

      case (r_state)
         S_IDLE: begin
            if (r_settle == 2'd3) begin
               if (r_sync[1]) begin
                  w_state = S_LOAD;
               end else begin
                  w_state      = S_RUN;
                  w_core_reset = 1'b0;
                  w_boot       = 1'b1;
               end
            end else begin
               w_settle = r_settle + 2'd1;
            end
         end
         S_LOAD: begin
            if (rx_valid_i) begin
               w_word     = w_asm;
               w_byte_idx = r_byte_idx + 2'd1;
               if (r_byte_idx == 2'd3) begin
                  if (w_asm == END_WORD) begin
                     w_state = S_DONE;
                     w_boot  = 1'b1;
                  end else begin
                     w_state     = S_WRITE;
                     w_mem_req   = 1'b1;
                     w_mem_we    = 1'b1;
                     w_mem_addr  = r_word_cnt;
                     w_mem_wdata = w_asm;
                  end
               end
            end
         end
         S_WRITE: begin
            if (rx_valid_i) begin
               w_err = 1'b1;
            end
            if (mem_gnt_i) begin
               w_mem_req = 1'b0;
               w_mem_we  = 1'b0;
               // Last address written: stop loading rather than wrap onto word 0.
               if (r_word_cnt == {ADDR_W{1'b1}}) begin
                  w_err   = 1'b1;
                  w_state = S_DONE;
                  w_boot  = 1'b1;
               end else begin
                  w_word_cnt = r_word_cnt + 1'b1;
                  w_state    = S_LOAD;
               end
            end
         end
         S_DONE: begin
            w_state      = S_RUN;
            w_core_reset = 1'b0;
         end
         S_RUN: begin
            if (w_prog_rise) begin
               w_state      = S_LOAD;
               w_core_reset = 1'b1;
               w_boot       = 1'b0;
               w_word_cnt   = '0;
               w_byte_idx   = 2'd0;
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign mem_req_o    = w_run ? core_req_i  : r_mem_req;
   assign mem_we_o     = w_run ? 1'b0        : r_mem_we;
   assign mem_addr_o   = w_run ? core_addr_i : r_mem_addr;
   assign mem_wdata_o  = r_mem_wdata;
   assign core_gnt_o   = w_run & mem_gnt_i;
   assign core_reset_o = r_core_reset;
   assign boot_o       = r_boot;
   assign err_o        = r_err;

endmodule

// File: tb/tb_prog_boot_ctrl.sv
// Scoreboard bench for prog_boot_ctrl: byte-stream reference model feeds expected writes, a monitor checks them.
module tb_prog_boot_ctrl;

   localparam logic [31:0] END_W = 32'h0000_0FFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, prog, rx_valid, rx_valid2, core_req, mem_gnt;
   logic [7:0]  rx_data;
   logic [12:0] core_addr;
   logic [1:0]  core_addr2;

   logic        core_gnt1, mem_req1, mem_we1, core_reset1, boot1, err1;
   logic [12:0] mem_addr1;
   logic [31:0] mem_wdata1;
   logic        core_gnt2, mem_req2, mem_we2, core_reset2, boot2, err2;
   logic [1:0]  mem_addr2;
   logic [31:0] mem_wdata2;

   assign core_addr2 = core_addr[1:0];

   prog_boot_ctrl #(.ADDR_W(13), .END_WORD(END_W)) u_dut (
      .clock(clk), .reset(rst), .prog_i(prog), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
      .core_req_i(core_req), .core_addr_i(core_addr), .core_gnt_o(core_gnt1),
      .mem_req_o(mem_req1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1), .mem_wdata_o(mem_wdata1),
      .mem_gnt_i(mem_gnt), .core_reset_o(core_reset1), .boot_o(boot1), .err_o(err1));

   prog_boot_ctrl #(.ADDR_W(2), .END_WORD(END_W)) u_dut2 (
      .clock(clk), .reset(rst), .prog_i(prog), .rx_valid_i(rx_valid2), .rx_data_i(rx_data),
      .core_req_i(core_req), .core_addr_i(core_addr2), .core_gnt_o(core_gnt2),
      .mem_req_o(mem_req2), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2), .mem_wdata_o(mem_wdata2),
      .mem_gnt_i(mem_gnt), .core_reset_o(core_reset2), .boot_o(boot2), .err_o(err2));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference model: the loader seen as a byte stream cut into LE words.
   typedef struct {int addr; logic [31:0] data;} wr_t;
   wr_t         q1[$];
   wr_t         q2[$];
   int          m_cnt[2];
   int          m_nb[2];
   logic [31:0] m_word[2];
   bit          m_load[2];
   bit          m_err[2];
   int          m_max[2] = '{8191, 3};

   function automatic void model_start(int d);
      m_cnt[d] = 0; m_nb[d] = 0; m_word[d] = 32'd0; m_load[d] = 1'b1;
   endfunction

   function automatic void model_byte(int d, logic [7:0] b);
      wr_t w;
      if (!m_load[d]) return;
      m_word[d] = m_word[d] | (32'(b) << (8 * m_nb[d]));
      m_nb[d]++;
      if (m_nb[d] == 4) begin
         w.addr = m_cnt[d];
         w.data = m_word[d];
         m_nb[d] = 0;
         m_word[d] = 32'd0;
         if (w.data == END_W) begin
            m_load[d] = 1'b0;
         end else begin
            if (d == 0) q1.push_back(w); else q2.push_back(w);
            if (m_cnt[d] == m_max[d]) begin
               m_load[d] = 1'b0;
               m_err[d]  = 1'b1;
            end else begin
               m_cnt[d]++;
            end
         end
      end
   endfunction

   bit          p_stall[2];
   logic [31:0] p_addr[2];
   logic [31:0] p_data[2];

   task automatic mon(input int d, input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic creset, input logic cgnt);
      wr_t e;
      if (req && we) begin
         if (p_stall[d]) begin
            chk($sformatf("stall_addr%0d", d), addr, p_addr[d]);
            chk($sformatf("stall_data%0d", d), data, p_data[d]);
         end
         if (mem_gnt) begin
            p_stall[d] = 1'b0;
            if ((d == 0 && q1.size() == 0) || (d == 1 && q2.size() == 0)) begin
               checks++; errors++;
               $display("FAIL unexpected_write%0d actual=%h@%0h required=none", d, data, addr);
            end else begin
               e = (d == 0) ? q1.pop_front() : q2.pop_front();
               chk($sformatf("wr_addr%0d", d), addr, e.addr);
               chk($sformatf("wr_data%0d", d), data, e.data);
            end
         end else begin
            p_stall[d] = 1'b1; p_addr[d] = addr; p_data[d] = data;
         end
      end else begin
         p_stall[d] = 1'b0;
      end
      if (creset && core_req && mem_gnt) chk($sformatf("gnt_blocked%0d", d), cgnt, 1'b0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            p_stall[0] = 1'b0; p_stall[1] = 1'b0;
         end else begin
            mon(0, mem_req1, mem_we1, 32'(mem_addr1), mem_wdata1, core_reset1, core_gnt1);
            mon(1, mem_req2, mem_we2, 32'(mem_addr2), mem_wdata2, core_reset2, core_gnt2);
         end
      end
   end

   bit gnt_rand = 1'b0;
   bit en2 = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (gnt_rand) mem_gnt = 1'($urandom_range(0, 1));
      end
   end

   task automatic wait_no_write();
      int n = 0;
      while (mem_req1 && mem_we1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++; errors++;
         $display("FAIL write_timeout actual=stalled required=grant");
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      wait_no_write();
      rx_data  = b;
      rx_valid = 1'b1;
      rx_valid2 = en2;
      model_byte(0, b);
      if (en2) model_byte(1, b);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_valid2 = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == END_W) w = 32'h1234_5678;
      return w;
   endfunction

   task automatic wait_core_reset(input logic v, input int lim);
      int n = 0;
      while (core_reset1 !== v && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("core_reset_wait", core_reset1, v);
   endtask

   logic [7:0] prog_bytes [12] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                                   8'hFF, 8'h0F, 8'h00, 8'h00};

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; prog = 1'b0; rx_valid = 1'b0; rx_valid2 = 1'b0; rx_data = 8'h00;
      core_req = 1'b1; core_addr = 13'h12; mem_gnt = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_core_reset", core_reset1, 1'b1);
      chk("rst_boot", boot1, 1'b0);
      chk("rst_err", err1, 1'b0);
      chk("rst_mem_req", mem_req1, 1'b0);
      chk("rst_mem_we", mem_we1, 1'b0);
      chk("rst_mem_addr", 32'(mem_addr1), 32'd0);
      chk("rst_mem_wdata", mem_wdata1, 32'd0);
      chk("rst_core_gnt", core_gnt1, 1'b0);

      // Boot straight to the existing image.
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("idle_core_reset", core_reset1, 1'b1);
         @(negedge clk);
      end
      chk("run_core_reset", core_reset1, 1'b0);
      chk("run_boot", boot1, 1'b1);
      chk("run_mem_req", mem_req1, 1'b1);
      chk("run_mem_we", mem_we1, 1'b0);
      chk("run_mem_addr", 32'(mem_addr1), 32'h12);
      chk("run_core_gnt", core_gnt1, 1'b1);
      mem_gnt = 1'b0; core_addr = 13'h5;
      #1;
      chk("run_core_gnt_low", core_gnt1, 1'b0);
      chk("run_mem_addr2", 32'(mem_addr1), 32'h5);

      // Re-program with the reference byte sequence and grant tied high.
      @(negedge clk);
      mem_gnt = 1'b1;
      prog = 1'b1;
      wait_core_reset(1'b1, 8);
      chk("load_boot", boot1, 1'b0);
      model_start(0);
      for (int i = 0; i < 12; i++) send_byte(prog_bytes[i]);
      chk("done_core_reset", core_reset1, 1'b1);
      chk("done_boot", boot1, 1'b1);
      @(negedge clk);
      chk("release_core_reset", core_reset1, 1'b0);
      chk("p2_queue_empty", q1.size(), 0);
      chk("p2_err", err1, 1'b0);

      // Random words under random grant, plus a long stall with an overrun byte.
      prog = 1'b0;
      repeat (4) @(negedge clk);
      prog = 1'b1;
      wait_core_reset(1'b1, 10);
      model_start(0);
      gnt_rand = 1'b1;
      for (int i = 0; i < 6; i++) send_word(rand_word());
      wait_no_write();
      gnt_rand = 1'b0;
      mem_gnt = 1'b0;
      send_word(rand_word());
      chk("stall_req", mem_req1, 1'b1);
      repeat (2) @(negedge clk);
      rx_data = 8'($urandom); rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      m_err[0] = 1'b1;
      chk("overrun_err", err1, 1'b1);
      repeat (3) @(negedge clk);
      chk("overrun_err_sticky", err1, 1'b1);
      mem_gnt = 1'b1;
      @(negedge clk);
      gnt_rand = 1'b1;
      for (int i = 0; i < 3; i++) send_word(rand_word());
      send_word(END_W);
      repeat (3) @(negedge clk);
      chk("p3_core_reset", core_reset1, 1'b0);
      chk("p3_boot", boot1, 1'b1);
      chk("p3_err", err1, m_err[0]);
      chk("p3_queue_empty", q1.size(), 0);

      // Reset while a write is stalled: request drops at once, image abandoned.
      gnt_rand = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_err[0] = 1'b0; m_err[1] = 1'b0;
      chk("rst_clears_err", err1, 1'b0);
      repeat (5) @(negedge clk);
      en2 = 1'b1;
      model_start(0); model_start(1);
      mem_gnt = 1'b0;
      send_word(rand_word());
      chk("pre_rst_req", mem_req1, 1'b1);
      #1 rst = 1'b1;
      #1 chk("rst_drops_req", mem_req1, 1'b0);
      q1.delete(); q2.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      model_start(0); model_start(1);
      mem_gnt = 1'b1;
      // Reset after two bytes of a word; reload must realign on byte 0.
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      model_start(0); model_start(1);
      gnt_rand = 1'b1;
      for (int i = 0; i < 5; i++) send_word(rand_word());
      send_word(END_W);
      repeat (3) @(negedge clk);
      chk("p4_err1", err1, m_err[0]);
      chk("p4_err2", err2, m_err[1]);
      chk("p4_core_reset1", core_reset1, 1'b0);
      chk("p4_core_reset2", core_reset2, 1'b0);
      chk("p4_boot2", boot2, 1'b1);
      chk("p4_queue1_empty", q1.size(), 0);
      chk("p4_queue2_empty", q2.size(), 0);

      gnt_rand = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
